// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle integer multiply/divide unit for the EX stage.
// Owns the architectural HI/LO registers. MULT/MULTU/DIV/DIVU iterate
// WIDTH cycles in CALC, then FIX applies signs and writes HI/LO.
// MTHI/MTLO write in one cycle from IDLE.
// Build option: define EX_MULDIV_DIV_EN to compile the divide datapath.
// Without it, DIV/DIVU only pulse div_err for one cycle.
// Ports:
//   clk, reset (async, active-high), flush (sync abort)
//   start, op[2:0], op_a, op_b : decoded op and forwarded operands from ID/EX
//   hi, lo     : HI/LO registers
//   busy       : unit is not idle
//   stall_req  : combinational hold request to the hazard unit
//   div_err    : registered one-cycle pulse (divide not built)
module ex_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall_req,
    output logic             div_err
);
    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] acc;
    logic               neg_res;
    logic               mul_req, div_req, long_req, sgn_op;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_step, prod;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
`ifdef EX_MULDIV_DIV_EN
    logic               is_div, neg_rem, div_zero;
    logic [WIDTH-1:0]   orig_a, quo, rem;
    logic [WIDTH:0]     rem_shift, diff;
`endif

    // Request decode and operand magnitudes for capture in IDLE
    always_comb begin
        mul_req = start && (op == OP_MULT || op == OP_MULTU);
        div_req = start && (op == OP_DIV || op == OP_DIVU);
`ifdef EX_MULDIV_DIV_EN
        long_req = mul_req || div_req;
`else
        long_req = mul_req;
`endif
        sgn_op = (op == OP_MULT) || (op == OP_DIV);
        abs_a  = (sgn_op && op_a[WIDTH-1]) ? -op_a : op_a;
        abs_b  = (sgn_op && op_b[WIDTH-1]) ? -op_b : op_b;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and stall request
    always_comb begin
        state_nxt = state;
        stall_req = 1'b0;
        case (state)
            IDLE: begin
                if (long_req) begin
                    stall_req = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                stall_req = 1'b1;
                if (cnt == CNT_LAST) state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    assign busy = (state != IDLE);

    // One iteration: right-shifting shift-add multiply, or restoring divide
    // with the remainder in acc's upper half and quotient bits entering the lower half
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a & {WIDTH{mag_b[0]}}};
        acc_step = {mul_sum, acc[WIDTH-1:1]};
`ifdef EX_MULDIV_DIV_EN
        rem_shift = {acc[2*WIDTH-1:WIDTH], mag_a[WIDTH-1]};
        diff      = rem_shift - {1'b0, mag_b};
        if (is_div) begin
            acc_step = diff[WIDTH] ? {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
`endif
    end

    // Sign fix-up applied in FIX
    always_comb begin
        prod   = neg_res ? -acc : acc;
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
`ifdef EX_MULDIV_DIV_EN
        quo = acc[WIDTH-1:0];
        rem = acc[2*WIDTH-1:WIDTH];
        if (is_div) begin
            if (div_zero) begin
                fix_lo = '1;
                fix_hi = orig_a;
            end else begin
                fix_lo = neg_res ? -quo : quo;
                fix_hi = neg_rem ? -rem : rem;
            end
        end
`endif
    end

    // Datapath and HI/LO registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            acc     <= '0;
            neg_res <= 1'b0;
            hi      <= '0;
            lo      <= '0;
`ifdef EX_MULDIV_DIV_EN
            is_div   <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            orig_a   <= '0;
`endif
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && op == OP_MTHI) hi <= op_a;
                    if (start && op == OP_MTLO) lo <= op_a;
                    if (long_req) begin
                        mag_a   <= abs_a;
                        mag_b   <= abs_b;
                        acc     <= '0;
                        cnt     <= '0;
                        neg_res <= sgn_op && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
`ifdef EX_MULDIV_DIV_EN
                        is_div   <= div_req;
                        neg_rem  <= sgn_op && op_a[WIDTH-1];
                        div_zero <= (op_b == '0);
                        orig_a   <= op_a;
`endif
                    end
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    acc <= acc_step;
`ifdef EX_MULDIV_DIV_EN
                    if (is_div) mag_a <= mag_a << 1;
                    else        mag_b <= mag_b >> 1;
`else
                    mag_b <= mag_b >> 1;
`endif
                end
                FIX: begin
                    hi  <= fix_hi;
                    lo  <= fix_lo;
                    cnt <= '0;
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Divide-not-built error pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_err <= 1'b0;
        end else begin
`ifdef EX_MULDIV_DIV_EN
            div_err <= 1'b0;
`else
            div_err <= (state == IDLE) && div_req && !flush;
`endif
        end
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Multi-cycle integer multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the decoded operation and forwarded operands leaving ID/EX, iterates 32 cycles for MULT/MULTU/DIV/DIVU, and owns the architectural HI/LO registers. While an operation is iterating it raises `stall_req`, which the hazard unit folds into `stall[2]` so that ID/EX and earlier stages hold.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI/LO are WIDTH each; iteration count = WIDTH.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `flush` in 1: synchronous abort, highest priority after reset.
- `start` in 1: ID/EX holds a valid muldiv instruction this cycle.
- `op` in 3: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (ignored).
- `op_a` in WIDTH: rs operand, forwarded; dividend / multiplicand / MTHI-MTLO source.
- `op_b` in WIDTH: rt operand, forwarded; divisor / multiplier.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.
- `busy` out 1: state != IDLE.
- `stall_req` out 1: combinational hold request to the hazard unit.
- `div_err` out 1: one-cycle pulse, registered.

## Operation
- States: IDLE, CALC, FIX.
- IDLE with `start` and op MULT/MULTU/DIV/DIVU: capture operand magnitudes (the signed ops take absolute values), capture the result-sign flags, clear the 2*WIDTH accumulator, set counter = 0, and go to CALC.
- IDLE with `start` and op MTHI/MTLO: write `op_a` to `hi`/`lo` at that edge; stay in IDLE; no stall.
- CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Counter increments. Leave for FIX after the step with counter = WIDTH-1.
- FIX: apply signs and write `hi`/`lo`, then return to IDLE. `start` is ignored in FIX, because the same instruction is still presented.
- Multiply result: {hi,lo} = 64-bit product. Signed product is negated when operand signs differ.
- Divide result: lo = quotient, hi = remainder. Signed: the quotient is negated when the signs differ, and the remainder takes the dividend's sign.
- 0x80000000 / -1 gives lo = 0x80000000, hi = 0.
- Divide by zero, signed or unsigned: lo = 0xFFFFFFFF, hi = `op_a`. The full 33-cycle latency is still taken.
- `stall_req` = (state==IDLE && start && op in {001..100}) || state==CALC.
- `flush`: state goes to IDLE, the counter clears, and `hi`/`lo` are unchanged. This includes flush during FIX, in which case there is no write. `flush` also blocks acceptance in IDLE that cycle.
- Reserved op 111 and op 000: no effect.

## Timing
- Reset values: `hi`=0, `lo`=0, state=IDLE, `busy`=0, `div_err`=0. `stall_req`=0 unless `start` is high with a long op.
- Accept edge E0. CALC covers cycles E0+1 … E0+32. FIX is the cycle after E0+32. `hi`/`lo` update at edge E0+33.
- `stall_req` is high for 33 consecutive cycles (the accept cycle plus 32 CALC cycles). It is low in FIX, so ID/EX advances at the FIX edge.
- An MFHI/MFLO entering EX the cycle after FIX reads the new `hi`/`lo`. No bypass path is required.
- MTHI/MTLO: 1-cycle, visible the cycle after the edge.
- Reset mid-operation: immediate return to the reset values, with no partial HI/LO write.

## Configuration
- `EX_MULDIV_DIV_EN` defined: DIV/DIVU are implemented as described.
- Undefined: the divide datapath is not compiled. DIV/DIVU in IDLE are accepted for a single cycle only, with no stall and no state change. They pulse `div_err` the next cycle and leave `hi`/`lo` unchanged. Defined builds never assert `div_err`.

## Test plan
- MULT op_a=0xFFFFFFFD (−3), op_b=5 → at E0+33 hi=0xFFFFFFFF, lo=0xFFFFFFF1. `stall_req` is high for exactly 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV −7 / 2 (0xFFFFFFF9, 2) → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/0 → lo=0xFFFFFFFF, hi=100.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles → hi/lo update the edge after each. `stall_req` stays 0.
- Start MULT 6×7 and assert `flush` at E0+10 → busy drops the next cycle and hi/lo keep their prior values. A following MULT 6×7 gives lo=42, hi=0.
- Build without `EX_MULDIV_DIV_EN`: DIV 8/2 → no stall, `div_err` pulses one cycle, hi/lo unchanged.
